// File: rtl/eth_rx_speed_ctrl_if.sv
// eth_rx_speed_ctrl_if: status/control bundle between the speed controller and the GMII RX block.
interface eth_rx_speed_ctrl_if;
    logic gmii_rx_dv;
    logic start_packet;
    logic error_bad_frame;
    logic error_bad_fcs;
    logic m_axis_tvalid;
    logic m_axis_tlast;
    logic clk_enable;
    logic mii_select;
    modport master (
        input  gmii_rx_dv, start_packet, error_bad_frame, error_bad_fcs, m_axis_tvalid, m_axis_tlast,
        output clk_enable, mii_select
    );
    modport slave (
        output gmii_rx_dv, start_packet, error_bad_frame, error_bad_fcs, m_axis_tvalid, m_axis_tlast,
        input  clk_enable, mii_select
    );
endinterface

// File: rtl/eth_rx_speed_ctrl.sv
// eth_rx_speed_ctrl: frame-safe RX speed switching, clock-enable generation and saturating RX statistics.
module eth_rx_speed_ctrl #(
    parameter int CNT_WIDTH  = 16,
    parameter int SWITCH_GAP = 8,
    parameter int DIV_100M   = 5,
    parameter int DIV_10M    = 50
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           cfg_speed,
    input  logic                 cnt_clear,
    eth_rx_speed_ctrl_if.master  rx,
    output logic [1:0]           speed_active,
    output logic                 switch_pending,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic [CNT_WIDTH-1:0] bad_frame_cnt,
    output logic [CNT_WIDTH-1:0] bad_fcs_cnt
);
    localparam int GW = $clog2(SWITCH_GAP + 1);
    localparam int DW = $clog2((DIV_10M > DIV_100M ? DIV_10M : DIV_100M) + 1);
    typedef enum logic [1:0] {SWITCH, IDLE, FRAME} state_t;
    state_t          state, state_nx;
    logic [GW-1:0]   gap_cnt;
    logic [DW-1:0]   div_cnt, div_nx, div_last;
    logic [1:0]      norm;
    logic            mismatch, last, eof;
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c, input logic inc);
        return (&c || !inc) ? c : c + CNT_WIDTH'(1);
    endfunction
    always_comb begin
        norm           = cfg_speed[1] ? 2'b10 : cfg_speed;
        mismatch       = norm != speed_active;
        last           = state == SWITCH && gap_cnt == GW'(SWITCH_GAP - 1);
        eof            = rx.m_axis_tvalid && rx.m_axis_tlast;
        switch_pending = state != SWITCH && mismatch;
        div_last       = speed_active == 2'b01 ? DW'(DIV_100M - 1) : DW'(DIV_10M - 1);
        div_nx         = div_cnt == div_last ? '0 : div_cnt + DW'(1);
        state_nx       = state == SWITCH ? (last ? IDLE : SWITCH) :
                         state == IDLE   ? (rx.start_packet ? FRAME : (mismatch && !rx.gmii_rx_dv) ? SWITCH : IDLE) :
                         (eof ? IDLE : FRAME);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= SWITCH;
            gap_cnt       <= '0;
            div_cnt       <= '0;
            rx.clk_enable <= 1'b0;
            rx.mii_select <= 1'b0;
            speed_active  <= 2'b10;
        end else begin
            state         <= state_nx;
            gap_cnt       <= state == SWITCH ? gap_cnt + GW'(1) : '0;
            div_cnt       <= state == SWITCH ? '0 : div_nx;
            // the cycle leaving SWITCH always carries the first enable pulse
            rx.clk_enable <= state_nx != SWITCH && (state == SWITCH || speed_active == 2'b10 || div_nx == '0);
            if (last) begin
                speed_active  <= norm;
                rx.mii_select <= ~norm[1];
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt     <= '0;
            bad_frame_cnt <= '0;
            bad_fcs_cnt   <= '0;
        end else if (cnt_clear) begin
            frame_cnt     <= '0;
            bad_frame_cnt <= '0;
            bad_fcs_cnt   <= '0;
        end else begin
            frame_cnt     <= sat_inc(frame_cnt, eof);
            bad_frame_cnt <= sat_inc(bad_frame_cnt, rx.error_bad_frame);
            bad_fcs_cnt   <= sat_inc(bad_fcs_cnt, rx.error_bad_fcs);
        end
    end
endmodule

// File: tb/tb_eth_rx_speed_ctrl.sv
// tb_eth_rx_speed_ctrl: directed checks of speed switching, enable cadence and counters.
module tb_eth_rx_speed_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  cfg_speed = 2'b10;
    logic        cnt_clear = 1'b0;
    logic [1:0]  speed_active;
    logic        switch_pending;
    logic [15:0] frame_cnt, bad_frame_cnt, bad_fcs_cnt;
    int          n_tests = 0;
    int          n_fail  = 0;
    eth_rx_speed_ctrl_if rx ();
    eth_rx_speed_ctrl dut (
        .clk(clk), .rst(rst), .cfg_speed(cfg_speed), .cnt_clear(cnt_clear), .rx(rx.master),
        .speed_active(speed_active), .switch_pending(switch_pending),
        .frame_cnt(frame_cnt), .bad_frame_cnt(bad_frame_cnt), .bad_fcs_cnt(bad_fcs_cnt)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic gap_check(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk(tag, rx.clk_enable, 0);
            step();
        end
    endtask
    initial begin
        rx.gmii_rx_dv = 0; rx.start_packet = 0; rx.error_bad_frame = 0; rx.error_bad_fcs = 0;
        rx.m_axis_tvalid = 0; rx.m_axis_tlast = 0;
        step(3);
        chk("rst_ce", rx.clk_enable, 0);
        chk("rst_mii", rx.mii_select, 0);
        chk("rst_speed", speed_active, 2'b10);
        chk("rst_pend", switch_pending, 0);
        chk("rst_cnt", {frame_cnt, bad_fcs_cnt}, 0);
        // 1000M after release: 8-cycle gap then constant enable
        rst = 0;
        gap_check("g1000_gap");
        for (int i = 0; i < 5; i++) begin
            chk("g1000_ce", rx.clk_enable, 1);
            step();
        end
        chk("g1000_mii", rx.mii_select, 0);
        chk("g1000_speed", speed_active, 2'b10);
        // 100M after release: pulse every 5 starting right after the gap
        rst = 1; cfg_speed = 2'b01;
        step();
        rst = 0;
        gap_check("g100_gap");
        for (int i = 0; i < 15; i++) begin
            chk("g100_ce", rx.clk_enable, (i % 5) == 0);
            step();
        end
        chk("g100_mii", rx.mii_select, 1);
        chk("g100_speed", speed_active, 2'b01);
        // reset during a switch at 100M
        cfg_speed = 2'b00;
        step(3);
        chk("sw_ce", rx.clk_enable, 0);
        chk("sw_pend", switch_pending, 0);
        #2 rst = 1;
        #1;
        chk("async_speed", speed_active, 2'b10);
        chk("async_mii", rx.mii_select, 0);
        chk("async_ce", rx.clk_enable, 0);
        cfg_speed = 2'b01;
        step();
        rst = 0;
        gap_check("rel_gap");
        for (int i = 0; i < 6; i++) begin
            chk("rel_ce", rx.clk_enable, (i % 5) == 0);
            step();
        end
        chk("rel_speed", speed_active, 2'b01);
        // to 1000M, then request 10M while a frame is running
        cfg_speed = 2'b10;
        step(9);
        chk("to1g_speed", speed_active, 2'b10);
        chk("to1g_ce", rx.clk_enable, 1);
        rx.start_packet = 1;
        step();
        rx.start_packet = 0; rx.gmii_rx_dv = 1; cfg_speed = 2'b00;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("frm_ce", rx.clk_enable, 1);
            chk("frm_pend", switch_pending, 1);
            step();
        end
        rx.m_axis_tvalid = 1; rx.m_axis_tlast = 1;
        step();
        rx.m_axis_tvalid = 0; rx.m_axis_tlast = 0;
        for (int i = 0; i < 3; i++) begin
            chk("dv_hold_ce", rx.clk_enable, 1);
            chk("dv_hold_pend", switch_pending, 1);
            step();
        end
        chk("frame_cnt1", frame_cnt, 1);
        rx.gmii_rx_dv = 0;
        step();
        gap_check("g10_gap");
        for (int i = 0; i < 101; i++) begin
            chk("g10_ce", rx.clk_enable, (i % 50) == 0);
            step();
        end
        chk("g10_speed", speed_active, 2'b00);
        chk("g10_mii", rx.mii_select, 1);
        // start_packet wins over a same-cycle mismatch
        cfg_speed = 2'b11; rx.start_packet = 1;
        step();
        rx.start_packet = 0;
        for (int i = 0; i < 10; i++) begin
            chk("prio_pend", switch_pending, 1);
            step();
        end
        chk("prio_speed", speed_active, 2'b00);
        rx.m_axis_tvalid = 1; rx.m_axis_tlast = 1;
        step();
        rx.m_axis_tvalid = 0; rx.m_axis_tlast = 0;
        chk("prio_idle_pend", switch_pending, 1);
        step();
        chk("prio_sw_pend", switch_pending, 0);
        step(8);
        chk("prio_speed2", speed_active, 2'b10);
        chk("prio_ce", rx.clk_enable, 1);
        chk("frame_cnt2", frame_cnt, 2);
        // counters, clear priority, saturation
        rx.error_bad_frame = 1;
        step(3);
        rx.error_bad_frame = 0; rx.error_bad_fcs = 1;
        step(2);
        rx.error_bad_fcs = 0;
        chk("bad_frame3", bad_frame_cnt, 3);
        chk("bad_fcs2", bad_fcs_cnt, 2);
        chk("frame_keep", frame_cnt, 2);
        rx.error_bad_fcs = 1; cnt_clear = 1;
        step();
        rx.error_bad_fcs = 0; cnt_clear = 0;
        chk("clr_fcs", bad_fcs_cnt, 0);
        chk("clr_frame", bad_frame_cnt, 0);
        chk("clr_fcnt", frame_cnt, 0);
        rx.m_axis_tvalid = 1; rx.m_axis_tlast = 1;
        step(65534);
        chk("sat_pre", frame_cnt, 16'hFFFE);
        step(5);
        rx.m_axis_tvalid = 0; rx.m_axis_tlast = 0;
        chk("sat_hold", frame_cnt, 16'hFFFF);
        // pulse coinciding with reset is not counted
        rx.error_bad_frame = 1; rst = 1;
        step();
        rx.error_bad_frame = 0;
        chk("rst_pulse", bad_frame_cnt, 0);
        chk("rst_fcnt", frame_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
